// File: rtl/elevator_ctrl_n.sv
// elevator_ctrl_n: N-floor collective (SCAN) elevator controller.
// Latches hall-up, hall-down and car requests per floor and serves them while
// keeping direction as long as requests remain ahead, then reverses. Floor
// travel time and door dwell come from an internal cycle counter.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset; drops all pending requests
//   hall_up_req    hall up-call per floor (top floor bit ignored)
//   hall_dn_req    hall down-call per floor (floor 0 bit ignored)
//   car_req        in-car floor button per floor
//   current_floor  registered car position
//   moving_up      travelling upward
//   moving_down    travelling downward
//   door_open      door open at current_floor
//   pend_up/pend_dn/pend_car  latched request vectors
module elevator_ctrl_n #(
    parameter int NUM_FLOORS    = 4,
    parameter int FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] hall_up_req,
    input  logic [NUM_FLOORS-1:0] hall_dn_req,
    input  logic [NUM_FLOORS-1:0] car_req,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pend_up,
    output logic [NUM_FLOORS-1:0] pend_dn,
    output logic [NUM_FLOORS-1:0] pend_car
);

    localparam int TMAX  = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TMR_W = $clog2(TMAX + 1);
    localparam logic [TMR_W-1:0]      TRAVEL_LAST = TMR_W'(TRAVEL_CYCLES - 1);
    localparam logic [TMR_W-1:0]      DOOR_LAST   = TMR_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0]    TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [NUM_FLOORS-1:0] UP_VALID    = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam logic [NUM_FLOORS-1:0] DN_VALID    = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;
    typedef enum logic {DIR_UP, DIR_DN} dir_t;

    function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) m[i] = (FLOOR_W'(i) > f);
        return m;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) m[i] = (FLOOR_W'(i) < f);
        return m;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
        return NUM_FLOORS'(1) << f;
    endfunction

    state_t                  state_q, state_d;
    dir_t                    dir_q, dir_d;
    logic [FLOOR_W-1:0]      floor_q, floor_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [NUM_FLOORS-1:0]   up_q, dn_q, car_q;
    logic [NUM_FLOORS-1:0]   up_d, dn_d, car_d;

    logic [NUM_FLOORS-1:0]   all_pend, cur_bit, nxt_bit;
    logic [NUM_FLOORS-1:0]   set_up, set_dn, set_car, clr_up, clr_dn, clr_car;
    logic [FLOOR_W-1:0]      next_floor;
    logic                    req_above, req_below, ahead_fwd, ahead_rev;
    logic                    here, beyond_next, stop_next, door_hit;

    assign all_pend  = up_q | dn_q | car_q;
    assign cur_bit   = floor_bit(floor_q);
    assign here      = |(all_pend & cur_bit);
    assign req_above = |(all_pend & above_mask(floor_q));
    assign req_below = |(all_pend & below_mask(floor_q));
    assign ahead_fwd = (dir_q == DIR_UP) ? req_above : req_below;
    assign ahead_rev = (dir_q == DIR_UP) ? req_below : req_above;

    // Saturate at the end floors; MOVE is only entered with a request ahead,
    // so this guard never actually fires.
    always_comb begin
        next_floor = floor_q;
        if (dir_q == DIR_UP) begin
            if (floor_q != TOP_FLOOR) next_floor = floor_q + FLOOR_W'(1);
        end else begin
            if (floor_q != '0) next_floor = floor_q - FLOOR_W'(1);
        end
    end

    assign nxt_bit     = floor_bit(next_floor);
    assign beyond_next = (dir_q == DIR_UP) ? |(all_pend & above_mask(next_floor))
                                           : |(all_pend & below_mask(next_floor));
    assign stop_next   = |(car_q & nxt_bit)
                       | ((dir_q == DIR_UP) ? |(up_q & nxt_bit) : |(dn_q & nxt_bit))
                       | (|((up_q | dn_q) & nxt_bit) & ~beyond_next);

    // Any request at the open door's floor restarts the dwell instead of latching.
    assign door_hit = (state_q == S_DOOR) &&
                      |(((hall_up_req & UP_VALID) | (hall_dn_req & DN_VALID) | car_req) & cur_bit);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        floor_d = floor_q;
        timer_d = timer_q;
        set_up  = hall_up_req & UP_VALID;
        set_dn  = hall_dn_req & DN_VALID;
        set_car = car_req;
        clr_up  = '0;
        clr_dn  = '0;
        clr_car = '0;

        if (state_q == S_DOOR) begin
            set_up  = set_up  & ~cur_bit;
            set_dn  = set_dn  & ~cur_bit;
            set_car = set_car & ~cur_bit;
        end

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (here) begin
                    state_d = S_DOOR;
                    clr_up  = cur_bit;
                    clr_dn  = cur_bit;
                    clr_car = cur_bit;
                end else if (req_above) begin
                    dir_d   = DIR_UP;
                    state_d = S_MOVE;
                end else if (req_below) begin
                    dir_d   = DIR_DN;
                    state_d = S_MOVE;
                end
            end
            S_MOVE: begin
                if (timer_q == TRAVEL_LAST) begin
                    timer_d = '0;
                    floor_d = next_floor;
                    if (stop_next) begin
                        state_d = S_DOOR;
                        clr_car = nxt_bit;
                        if (dir_q == DIR_UP) clr_up = nxt_bit;
                        else                 clr_dn = nxt_bit;
                        // Nothing further this way: also serve the opposite
                        // call here and turn around.
                        if (!beyond_next) begin
                            if (dir_q == DIR_UP) begin
                                clr_dn = nxt_bit;
                                dir_d  = DIR_DN;
                            end else begin
                                clr_up = nxt_bit;
                                dir_d  = DIR_UP;
                            end
                        end
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_DOOR: begin
                if (door_hit) begin
                    timer_d = '0;
                end else if (timer_q == DOOR_LAST) begin
                    timer_d = '0;
                    if (ahead_fwd) begin
                        state_d = S_MOVE;
                    end else if (ahead_rev) begin
                        dir_d   = (dir_q == DIR_UP) ? DIR_DN : DIR_UP;
                        state_d = S_MOVE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        up_d  = (up_q  | set_up)  & ~clr_up;
        dn_d  = (dn_q  | set_dn)  & ~clr_dn;
        car_d = (car_q | set_car) & ~clr_car;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dir_q   <= DIR_UP;
            floor_q <= '0;
            timer_q <= '0;
            up_q    <= '0;
            dn_q    <= '0;
            car_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            floor_q <= floor_d;
            timer_q <= timer_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            car_q   <= car_d;
        end
    end

    assign current_floor = floor_q;
    assign moving_up     = (state_q == S_MOVE) && (dir_q == DIR_UP);
    assign moving_down   = (state_q == S_MOVE) && (dir_q == DIR_DN);
    assign door_open     = (state_q == S_DOOR);
    assign pend_up       = up_q;
    assign pend_dn       = dn_q;
    assign pend_car      = car_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Testbench for elevator_ctrl_n: directed scenarios with fixed expectations
// plus a randomized run compared each cycle against a behavioural model.
module tb_elevator_ctrl_n;

    localparam int N  = 4;
    localparam int FW = 2;
    localparam int T  = 8;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  hup = '0, hdn = '0, car = '0;
    logic [FW-1:0] current_floor;
    logic          moving_up, moving_down, door_open;
    logic [N-1:0]  pend_up, pend_dn, pend_car;

    int checks   = 0;
    int failures = 0;

    elevator_ctrl_n #(
        .NUM_FLOORS   (N),
        .FLOOR_W      (FW),
        .TRAVEL_CYCLES(T),
        .DOOR_CYCLES  (D)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hall_up_req  (hup),
        .hall_dn_req  (hdn),
        .car_req      (car),
        .current_floor(current_floor),
        .moving_up    (moving_up),
        .moving_down  (moving_down),
        .door_open    (door_open),
        .pend_up      (pend_up),
        .pend_dn      (pend_dn),
        .pend_car     (pend_car)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 moving, 2 door; dir: +1 / -1; cnt: cycles remaining.
    int m_floor, m_phase, m_dir, m_cnt;
    bit mu[N], md[N], mc[N];

    task automatic model_reset();
        m_floor = 0; m_phase = 0; m_dir = 1; m_cnt = 0;
        for (int i = 0; i < N; i++) begin mu[i] = 0; md[i] = 0; mc[i] = 0; end
    endtask

    function automatic bit m_any(int lo, int hi);
        for (int i = 0; i < N; i++)
            if (i >= lo && i <= hi && (mu[i] || md[i] || mc[i])) return 1;
        return 0;
    endfunction

    function automatic logic [N-1:0] pack(bit a[N]);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = a[i];
        return v;
    endfunction

    task automatic model_step(input logic [N-1:0] u, input logic [N-1:0] d, input logic [N-1:0] c);
        bit nu[N], nd[N], nc[N];
        bit restart, blk, ui, di, beyond, same, fwd, rev;
        int f, nf;
        if (!rst_n) begin model_reset(); return; end
        nu = mu; nd = md; nc = mc;
        f = m_floor;
        restart = 0;
        for (int i = 0; i < N; i++) begin
            blk = (m_phase == 2 && i == f);
            ui  = u[i] && (i != N-1);
            di  = d[i] && (i != 0);
            if (blk && (ui || di || c[i])) restart = 1;
            if (!blk) begin
                if (ui)   nu[i] = 1;
                if (di)   nd[i] = 1;
                if (c[i]) nc[i] = 1;
            end
        end
        case (m_phase)
            0: begin
                if (mu[f] || md[f] || mc[f]) begin
                    m_phase = 2; m_cnt = D;
                    nu[f] = 0; nd[f] = 0; nc[f] = 0;
                end else if (m_any(f + 1, N - 1)) begin
                    m_dir = 1; m_phase = 1; m_cnt = T;
                end else if (m_any(0, f - 1)) begin
                    m_dir = -1; m_phase = 1; m_cnt = T;
                end
            end
            1: begin
                m_cnt--;
                if (m_cnt == 0) begin
                    nf     = f + m_dir;
                    beyond = (m_dir > 0) ? m_any(nf + 1, N - 1) : m_any(0, nf - 1);
                    same   = (m_dir > 0) ? mu[nf] : md[nf];
                    m_floor = nf;
                    m_cnt   = T;
                    if (mc[nf] || same || ((mu[nf] || md[nf]) && !beyond)) begin
                        m_phase = 2; m_cnt = D;
                        nc[nf] = 0;
                        if (m_dir > 0) nu[nf] = 0; else nd[nf] = 0;
                        if (!beyond) begin
                            if (m_dir > 0) nd[nf] = 0; else nu[nf] = 0;
                            m_dir = -m_dir;
                        end
                    end
                end
            end
            default: begin
                if (restart) begin
                    m_cnt = D;
                end else begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        fwd = (m_dir > 0) ? m_any(f + 1, N - 1) : m_any(0, f - 1);
                        rev = (m_dir > 0) ? m_any(0, f - 1) : m_any(f + 1, N - 1);
                        if (fwd) begin
                            m_phase = 1; m_cnt = T;
                        end else if (rev) begin
                            m_dir = -m_dir; m_phase = 1; m_cnt = T;
                        end else begin
                            m_phase = 0;
                        end
                    end
                end
            end
        endcase
        mu = nu; md = nd; mc = nc;
    endtask

    // Drive inputs (from a falling edge), advance one rising edge, return on the next falling edge.
    task automatic tick(input logic [N-1:0] u, input logic [N-1:0] d, input logic [N-1:0] c);
        hup = u; hdn = d; car = c;
        @(posedge clk);
        model_step(u, d, c);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; hup = '0; hdn = '0; car = '0;
        model_reset();
        tick('0, '0, '0);
        tick('0, '0, '0);
        rst_n = 1'b1;
        tick('0, '0, '0);
    endtask

    function automatic bit quiet();
        return !moving_up && !moving_down && !door_open &&
               pend_up == '0 && pend_dn == '0 && pend_car == '0;
    endfunction

    // Runs until idle with nothing pending, recording the floor of each door opening.
    task automatic run_collect(input int budget, output int doors[$], output bit ok);
        bit prev_door;
        prev_door = door_open;
        doors = {};
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            tick('0, '0, '0);
            if (door_open && !prev_door) doors.push_back(int'(current_floor));
            prev_door = door_open;
            if (quiet()) begin ok = 1; break; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [3*N+FW+2:0] obs;
        rst_n = 1'b0; hup = '0; hdn = '0; car = '0;
        model_reset();
        #1;
        obs = {current_floor, moving_up, moving_down, door_open, pend_up, pend_dn, pend_car};
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_values: got %h required 0", obs);
        end
        @(negedge clk);
        tick('0, '0, '0);
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick('0, '0, '0);
            obs = {current_floor, moving_up, moving_down, door_open, pend_up, pend_dn, pend_car};
            checks++;
            if (obs !== '0) begin
                failures++;
                $display("FAIL reset_idle cycle %0d: got %h required 0", k, obs);
            end
        end
    endtask

    task automatic test_single_floor();
        logic [FW-1:0] exp_floor;
        do_reset();
        tick('0, '0, 4'b0100);
        checks++;
        if (pend_car !== 4'b0100 || moving_up !== 1'b0) begin
            failures++;
            $display("FAIL single_latch: pend_car=%b moving_up=%b required 0100/0", pend_car, moving_up);
        end
        for (int k = 1; k <= 21; k++) begin
            tick('0, '0, '0);
            if (k <= 16) begin
                exp_floor = (k <= 8) ? 2'd0 : 2'd1;
                checks++;
                if (moving_up !== 1'b1 || door_open !== 1'b0 || current_floor !== exp_floor) begin
                    failures++;
                    $display("FAIL single_move k=%0d: up=%b door=%b floor=%0d required 1/0/%0d",
                             k, moving_up, door_open, current_floor, exp_floor);
                end
            end else if (k <= 20) begin
                checks++;
                if (door_open !== 1'b1 || moving_up !== 1'b0 || current_floor !== 2'd2 || pend_car !== '0) begin
                    failures++;
                    $display("FAIL single_door k=%0d: door=%b up=%b floor=%0d pend_car=%b required 1/0/2/0000",
                             k, door_open, moving_up, current_floor, pend_car);
                end
            end else begin
                checks++;
                if (!quiet() || current_floor !== 2'd2) begin
                    failures++;
                    $display("FAIL single_idle: door=%b up=%b floor=%0d required idle at 2",
                             door_open, moving_up, current_floor);
                end
            end
        end
    endtask

    task automatic test_collective();
        int doors[$];
        bit ok;
        bit prev_door;
        bit seen_clear;
        do_reset();
        tick(4'b0100, 4'b0010, 4'b1000);
        prev_door = 0;
        seen_clear = 0;
        doors = {};
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            tick('0, '0, '0);
            if (door_open && !prev_door) begin
                doors.push_back(int'(current_floor));
                if (doors.size() == 1) begin
                    checks++;
                    if (pend_up[2] !== 1'b0 || pend_car[3] !== 1'b1 || pend_dn[1] !== 1'b1) begin
                        failures++;
                        $display("FAIL collect_first_stop: up=%b dn=%b car=%b required up[2]=0 dn[1]=1 car[3]=1",
                                 pend_up, pend_dn, pend_car);
                    end
                end
            end
            prev_door = door_open;
            if (quiet()) begin ok = 1; break; end
        end
        checks++;
        if (!ok || doors.size() != 3 || doors[0] != 2 || doors[1] != 3 || doors[2] != 1) begin
            failures++;
            $display("FAIL collect_order: done=%0d stops=%p required 2,3,1", ok, doors);
        end
        checks++;
        if (current_floor !== 2'd1) begin
            failures++;
            $display("FAIL collect_end_floor: got %0d required 1", current_floor);
        end
    endtask

    task automatic test_door_here();
        do_reset();
        tick(4'b0001, '0, '0);
        checks++;
        if (pend_up !== 4'b0001 || door_open !== 1'b0) begin
            failures++;
            $display("FAIL here_latch: pend_up=%b door=%b required 0001/0", pend_up, door_open);
        end
        for (int k = 1; k <= 3; k++) begin
            tick('0, '0, '0);
            checks++;
            if (door_open !== 1'b1 || moving_up !== 1'b0 || moving_down !== 1'b0 || pend_up !== '0) begin
                failures++;
                $display("FAIL here_door c%0d: door=%b up=%b dn=%b pend_up=%b required 1/0/0/0000",
                         k, door_open, moving_up, moving_down, pend_up);
            end
        end
        tick('0, '0, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick('0, '0, '0);
            checks++;
            if (door_open !== (k < 4) || pend_car !== '0) begin
                failures++;
                $display("FAIL here_restart k=%0d: door=%b pend_car=%b required %0d/0000",
                         k, door_open, pend_car, (k < 4));
            end
        end
    endtask

    task automatic test_up_first();
        int doors[$];
        bit ok;
        do_reset();
        tick('0, '0, 4'b0100);
        run_collect(200, doors, ok);
        checks++;
        if (!ok || current_floor !== 2'd2) begin
            failures++;
            $display("FAIL upfirst_setup: done=%0d floor=%0d required floor 2", ok, current_floor);
        end
        tick('0, '0, 4'b1001);
        run_collect(300, doors, ok);
        checks++;
        if (!ok || doors.size() != 2 || doors[0] != 3 || doors[1] != 0) begin
            failures++;
            $display("FAIL upfirst_order: done=%0d stops=%p required 3,0", ok, doors);
        end
        checks++;
        if (pend_car !== '0 || current_floor !== 2'd0) begin
            failures++;
            $display("FAIL upfirst_end: pend_car=%b floor=%0d required 0000/0", pend_car, current_floor);
        end
    endtask

    task automatic test_reset_mid_move();
        bit found;
        do_reset();
        tick('0, '0, 4'b1000);
        found = 0;
        for (int k = 0; k < 60; k++) begin
            tick('0, '0, '0);
            if (current_floor == 2'd1 && moving_up) begin found = 1; break; end
        end
        tick('0, '0, '0);
        tick('0, '0, '0);
        checks++;
        if (!found || pend_car !== 4'b1000 || current_floor !== 2'd1 || moving_up !== 1'b1) begin
            failures++;
            $display("FAIL midmove_setup: found=%0d pend_car=%b floor=%0d up=%b required 1/1000/1/1",
                     found, pend_car, current_floor, moving_up);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (current_floor !== '0 || moving_up !== 1'b0 || moving_down !== 1'b0 || pend_car !== '0) begin
            failures++;
            $display("FAIL midmove_abort: floor=%0d up=%b dn=%b pend_car=%b required 0/0/0/0000",
                     current_floor, moving_up, moving_down, pend_car);
        end
        @(negedge clk);
        tick('0, '0, '0);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick('0, '0, '0);
            checks++;
            if (!quiet() || current_floor !== '0) begin
                failures++;
                $display("FAIL midmove_after k=%0d: floor=%0d up=%b door=%b pend_car=%b required idle at 0",
                         k, current_floor, moving_up, door_open, pend_car);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] u, d, c;
        logic [3*N+FW+2:0] exp_v, obs_v;
        int which;
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            u = '0; d = '0; c = '0;
            if ($urandom_range(0, 5) == 0) begin
                which = $urandom_range(0, 2);
                case (which)
                    0: u[$urandom_range(0, N-1)] = 1'b1;
                    1: d[$urandom_range(0, N-1)] = 1'b1;
                    default: c[$urandom_range(0, N-1)] = 1'b1;
                endcase
            end
            tick(u, d, c);
            exp_v = {FW'(m_floor), (m_phase == 1 && m_dir > 0), (m_phase == 1 && m_dir < 0),
                     (m_phase == 2), pack(mu), pack(md), pack(mc)};
            obs_v = {current_floor, moving_up, moving_down, door_open, pend_up, pend_dn, pend_car};
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL random cycle %0d: got %h required %h", k, obs_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_floor();
        test_collective();
        test_door_here();
        test_up_first();
        test_reset_mid_move();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
